// File: rtl/input_datapath_pkg.sv
// Shared constants and receive-state encoding for the matrix operand datapaths.
package input_datapath_pkg;
  localparam int IN_WIDTH  = 64;
  localparam int OUT_WIDTH = 512;
  localparam int BEATS     = OUT_WIDTH / IN_WIDTH;
  localparam int CNT_W     = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } rx_state_e;
endpackage

// File: rtl/input_datapath_if.sv
// Source-beat and assembled-block handshakes between upstream, datapath and loader.
interface input_datapath_if;
  import input_datapath_pkg::*;

  // Both channels: a transfer happens on a rising edge where valid && ready;
  // a producer holds valid and data stable until that transfer occurs.
  logic                 src_valid;
  logic [IN_WIDTH-1:0]  src_data;
  logic                 src_ready;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_ready;

  modport master (
    output src_valid, src_data, out_ready,
    input  src_ready, out_valid, out_data
  );

  modport slave (
    input  src_valid, src_data, out_ready,
    output src_ready, out_valid, out_data
  );
endinterface

// File: rtl/input_datapath_beat_counter.sv
// Saturating count of beats captured into the current block.
module beat_counter
  import input_datapath_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             full
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (inc && (r_count != CNT_W'(BEATS))) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;
  assign full  = (r_count == CNT_W'(BEATS));
endmodule

// File: rtl/input_datapath.sv
// Assembles BEATS upstream words, MSB slice first, into one block for the loader.
module input_datapath
  import input_datapath_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             abort,
  input_datapath_if.slave  bus,
  output logic [CNT_W-1:0] beat_count,
  output logic             rx_done,
  output rx_state_e        dbg_state
);
  rx_state_e            r_state;
  rx_state_e            w_next;
  logic                 r_src_ready;
  logic                 r_out_valid;
  logic                 r_rx_done;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic [CNT_W-1:0]     w_count;
  logic                 w_full;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_handoff;
  logic                 w_clear;

  // Abort wins over a beat presented in the same cycle, including the last one.
  assign w_accept  = (r_state == COLLECT) && r_src_ready && bus.src_valid && !abort;
  assign w_last    = w_accept && (w_count == CNT_W'(BEATS - 1));
  assign w_handoff = (r_state == FULL) && r_out_valid && bus.out_ready;
  assign w_clear   = ((r_state == COLLECT) && abort) || w_handoff;

  beat_counter u_beat_counter (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .inc   (w_accept),
    .count (w_count),
    .full  (w_full)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (enable) w_next = COLLECT;
      COLLECT: begin
        if (abort)       w_next = IDLE;
        else if (w_last) w_next = FULL;
      end
      FULL:    if (w_handoff) w_next = enable ? COLLECT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_src_ready <= 1'b0;
      r_out_valid <= 1'b0;
      r_rx_done   <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_next;
      r_src_ready <= (w_next == COLLECT);
      r_out_valid <= (w_next == FULL);
      r_rx_done   <= w_handoff;
      for (int k = 0; k < BEATS; k++) begin
        if (w_accept && (w_count == CNT_W'(k))) begin
          r_out_data[OUT_WIDTH-1-k*IN_WIDTH -: IN_WIDTH] <= bus.src_data;
        end
      end
    end
  end

  assign bus.src_ready = r_src_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign beat_count    = w_count;
  assign rx_done       = r_rx_done;
  assign dbg_state     = r_state;

  logic w_unused;
  assign w_unused = w_full;
endmodule
